// File: rtl/mutex_pkg.sv
// rtl/mutex_pkg.sv - shared node-state/FSM types and rule guard for the mutex system model
package mutex_pkg;

    typedef enum logic [1:0] {
        NODE_I = 2'd0,
        NODE_T = 2'd1,
        NODE_C = 2'd2,
        NODE_E = 2'd3
    } node_state_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2
    } sched_state_t;

    // A node in T may only advance while it holds the shared token.
    function automatic logic rule_enabled(input node_state_t state, input logic x);
        return (state != NODE_T) || x;
    endfunction

endpackage

// File: rtl/mutex_rule_scheduler_rr_pick.sv
// rtl/mutex_rule_scheduler_rr_pick.sv - combinational round-robin pick starting after last
module rr_pick #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     en,
    input  logic [IDX_W-1:0] last,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand;

    // Walk offsets from far to near so the nearest enabled node wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = N; i >= 1; i--) begin
            cand = IDX_W'((int'(last) + i) % N);
            if (en[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mutex_rule_scheduler.sv
// rtl/mutex_rule_scheduler.sv - guarded one-hot rule scheduler for the mutex system model
// Optional starvation checker built when MUTEX_SCHED_STARVE_CHECK_EN is defined.
module mutex_rule_scheduler
    import mutex_pkg::*;
#(
    parameter  int N_NODES      = 3,
    parameter  int STARVE_LIMIT = 8,
    localparam int IDX_W        = (N_NODES > 1) ? $clog2(N_NODES) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [2*N_NODES-1:0]   n_state,
    input  logic                   x,
    input  logic                   step_valid,
    input  logic                   step_force,
    input  logic [IDX_W-1:0]       step_node,
    output logic                   step_ready,
    output logic [N_NODES-1:0]     io_en_a,
    output logic [IDX_W-1:0]       grant_id,
    output logic                   deadlock,
    output logic                   force_rej,
    output logic                   starve_err
);

    sched_state_t       state, state_next;
    logic [N_NODES-1:0] guard;
    logic               any_guard, accept, force_ok, rr_found, issue_go;
    logic [IDX_W-1:0]   rr_idx, pick, last;

    always_comb begin
        guard = '0;
        for (int k = 0; k < N_NODES; k++) begin
            guard[k] = rule_enabled(node_state_t'(n_state[2*k +: 2]), x);
        end
    end

    assign any_guard = |guard;
    assign accept    = step_valid & step_ready;
    assign force_ok  = (int'(step_node) < N_NODES) && guard[step_node];
    assign pick      = step_force ? step_node : rr_idx;
    assign issue_go  = accept & (step_force ? force_ok : rr_found);

    rr_pick #(.N(N_NODES), .IDX_W(IDX_W)) u_rr_pick (
        .en    (guard),
        .last  (last),
        .found (rr_found),
        .idx   (rr_idx)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (issue_go) state_next = ISSUE;
            ISSUE:   state_next = SETTLE;
            SETTLE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        step_ready = (state == IDLE) & any_guard;
        deadlock   = (state == IDLE) & ~any_guard;
    end

    // Grant is latched at acceptance so guard changes mid-firing cannot alter it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last      <= IDX_W'(N_NODES - 1);
            grant_id  <= '0;
            io_en_a   <= '0;
            force_rej <= 1'b0;
        end else begin
            force_rej <= accept & step_force & ~force_ok;
            io_en_a   <= issue_go ? (N_NODES'(1) << pick) : '0;
            if (issue_go) begin
                last     <= pick;
                grant_id <= pick;
            end
        end
    end

`ifdef MUTEX_SCHED_STARVE_CHECK_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] starve_cnt [N_NODES];
    logic          starve_hit;

    always_comb begin
        starve_hit = 1'b0;
        for (int k = 0; k < N_NODES; k++) begin
            if (starve_cnt[k] == CW'(STARVE_LIMIT)) starve_hit = 1'b1;
        end
    end

    // Disabled nodes hold their count: only being passed over while ready is starvation.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < N_NODES; k++) starve_cnt[k] <= '0;
            starve_err <= 1'b0;
        end else begin
            if (accept) begin
                for (int k = 0; k < N_NODES; k++) begin
                    if (issue_go && pick == IDX_W'(k)) begin
                        starve_cnt[k] <= '0;
                    end else if (guard[k] && starve_cnt[k] != CW'(STARVE_LIMIT)) begin
                        starve_cnt[k] <= starve_cnt[k] + 1'b1;
                    end
                end
            end
            starve_err <= starve_err | starve_hit;
        end
    end
`else
    assign starve_err = 1'b0;
`endif

endmodule

// File: tb/tb_mutex_rule_scheduler.sv
// tb/tb_mutex_rule_scheduler.sv - randomized self-checking bench for mutex_rule_scheduler
module tb_mutex_rule_scheduler;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] n_state = '0;
    logic       x = 1'b0;
    logic       step_valid = 1'b0;
    logic       step_force = 1'b0;
    logic [1:0] step_node = '0;
    logic       step_ready;
    logic [2:0] io_en_a;
    logic [1:0] grant_id;
    logic       deadlock;
    logic       force_rej;
    logic       starve_err;

    int         tests = 0;
    int         fails = 0;
    logic [1:0] m_last = 2'd2;

    mutex_rule_scheduler #(.N_NODES(3), .STARVE_LIMIT(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .n_state    (n_state),
        .x          (x),
        .step_valid (step_valid),
        .step_force (step_force),
        .step_node  (step_node),
        .step_ready (step_ready),
        .io_en_a    (io_en_a),
        .grant_id   (grant_id),
        .deadlock   (deadlock),
        .force_rej  (force_rej),
        .starve_err (starve_err)
    );

    always #5 clock = ~clock;

    function automatic logic [2:0] m_guard(input logic [5:0] ns, input logic xf);
        logic [2:0] g;
        logic [5:0] s;
        s = ns;
        for (int k = 0; k < 3; k++) begin
            g[k] = !(((s >> (2 * k)) & 6'd3) == 6'd1 && !xf);
        end
        return g;
    endfunction

    function automatic logic [1:0] m_rr(input logic [2:0] g, input logic [1:0] lst);
        for (int d = 1; d <= 3; d++) begin
            int c;
            c = (int'(lst) + d) % 3;
            if (g[c]) return 2'(c);
        end
        return 2'd0;
    endfunction

    task automatic apply_reset();
        step_valid = 1'b0;
        step_force = 1'b0;
        step_node  = 2'd0;
        reset      = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        m_last = 2'd2;
    endtask

    // Presents one step for a cycle from IDLE and returns what the DUT showed.
    task automatic fire(input logic f, input logic [1:0] node, output logic rdy,
                        output logic [2:0] en_o, output logic [1:0] gid, output logic rej);
        step_valid = 1'b1;
        step_force = f;
        step_node  = node;
        #1 rdy = step_ready;
        @(posedge clock);
        #1;
        step_valid = 1'b0;
        step_force = 1'b0;
        en_o = io_en_a;
        gid  = grant_id;
        rej  = force_rej;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset();
        n_state = 6'b000000;
        x = 1'b1;
        apply_reset();
        tests++; if (io_en_a !== 3'b000) begin fails++; $display("FAIL reset_en: got %b want 000", io_en_a); end
        tests++; if (grant_id !== 2'd0) begin fails++; $display("FAIL reset_gid: got %0d want 0", grant_id); end
        tests++; if (force_rej !== 1'b0) begin fails++; $display("FAIL reset_rej: got %b want 0", force_rej); end
        tests++; if (starve_err !== 1'b0) begin fails++; $display("FAIL reset_starve: got %b want 0", starve_err); end
        tests++; if (step_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", step_ready); end
        tests++; if (deadlock !== 1'b0) begin fails++; $display("FAIL reset_deadlock: got %b want 0", deadlock); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_en;
        logic       exp_rdy;
        n_state = 6'b000000;
        x = 1'b1;
        step_force = 1'b0;
        step_valid = 1'b1;
        @(posedge clock);
        for (int c = 0; c < 9; c++) begin
            #1;
            exp_en  = (c % 3 == 0) ? (3'b001 << (c / 3)) : 3'b000;
            exp_rdy = (c % 3 == 2);
            tests++; if (io_en_a !== exp_en) begin fails++; $display("FAIL b2b_en c=%0d: got %b want %b", c, io_en_a, exp_en); end
            tests++; if (step_ready !== exp_rdy) begin fails++; $display("FAIL b2b_ready c=%0d: got %b want %b", c, step_ready, exp_rdy); end
            if (c % 3 == 0) begin
                tests++; if (grant_id !== 2'(c / 3)) begin fails++; $display("FAIL b2b_gid c=%0d: got %0d want %0d", c, grant_id, c / 3); end
            end
            if (c < 8) @(posedge clock);
        end
        step_valid = 1'b0;
        m_last = 2'd2;
    endtask

    task automatic test_deadlock();
        logic       rdy, rej;
        logic [2:0] en_o;
        logic [1:0] gid, w;
        n_state = 6'b010101;
        x = 1'b0;
        #1;
        tests++; if (step_ready !== 1'b0) begin fails++; $display("FAIL dl_ready: got %b want 0", step_ready); end
        tests++; if (deadlock !== 1'b1) begin fails++; $display("FAIL dl_flag: got %b want 1", deadlock); end
        fire(1'b0, 2'd0, rdy, en_o, gid, rej);
        tests++; if (en_o !== 3'b000) begin fails++; $display("FAIL dl_noissue: got %b want 000", en_o); end
        x = 1'b1;
        #1;
        tests++; if (step_ready !== 1'b1) begin fails++; $display("FAIL dl_release_ready: got %b want 1", step_ready); end
        tests++; if (deadlock !== 1'b0) begin fails++; $display("FAIL dl_release_flag: got %b want 0", deadlock); end
        w = m_rr(m_guard(n_state, x), m_last);
        fire(1'b0, 2'd0, rdy, en_o, gid, rej);
        tests++; if (gid !== 2'd0 || gid !== w) begin fails++; $display("FAIL dl_first_grant: got %0d want 0", gid); end
        m_last = w;
    endtask

    task automatic test_force_reject();
        logic       rdy, rej;
        logic [2:0] en_o;
        logic [1:0] gid;
        n_state = 6'b010000;
        x = 1'b0;
        fire(1'b1, 2'd2, rdy, en_o, gid, rej);
        tests++; if (en_o !== 3'b000) begin fails++; $display("FAIL frej_en: got %b want 000", en_o); end
        tests++; if (rej !== 1'b1) begin fails++; $display("FAIL frej_pulse: got %b want 1", rej); end
        tests++; if (force_rej !== 1'b0) begin fails++; $display("FAIL frej_once: got %b want 0", force_rej); end
        n_state = 6'b000000;
        fire(1'b1, 2'd3, rdy, en_o, gid, rej);
        tests++; if (en_o !== 3'b000 || rej !== 1'b1) begin fails++; $display("FAIL frej_range: got en=%b rej=%b want en=000 rej=1", en_o, rej); end
        fire(1'b1, 2'd2, rdy, en_o, gid, rej);
        tests++; if (en_o !== 3'b100 || gid !== 2'd2 || rej !== 1'b0) begin fails++; $display("FAIL force_ok: got en=%b gid=%0d rej=%b want 100/2/0", en_o, gid, rej); end
        m_last = 2'd2;
    endtask

    task automatic test_reset_mid_issue();
        logic       rdy, rej;
        logic [2:0] en_o, exp_en;
        logic [1:0] gid;
        n_state = 6'b000000;
        x = 1'b1;
        exp_en = 3'b001 << m_rr(m_guard(n_state, x), m_last);
        step_valid = 1'b1;
        @(posedge clock);
        #1 step_valid = 1'b0;
        tests++; if (io_en_a !== exp_en) begin fails++; $display("FAIL mid_issue_en: got %b want %b", io_en_a, exp_en); end
        reset = 1'b0;
        #1;
        tests++; if (io_en_a !== 3'b000) begin fails++; $display("FAIL mid_reset_en: got %b want 000", io_en_a); end
        tests++; if (step_ready !== 1'b1 || grant_id !== 2'd0) begin fails++; $display("FAIL mid_reset_idle: got ready=%b gid=%0d want 1/0", step_ready, grant_id); end
        @(posedge clock);
        #1 reset = 1'b1;
        m_last = 2'd2;
        fire(1'b0, 2'd0, rdy, en_o, gid, rej);
        tests++; if (en_o !== 3'b001 || gid !== 2'd0) begin fails++; $display("FAIL post_reset_grant: got en=%b gid=%0d want 001/0", en_o, gid); end
        m_last = 2'd0;
    endtask

    task automatic test_random();
        logic       rdy, rej, f, ok;
        logic [2:0] en_o, g, exp_en;
        logic [1:0] gid, node, w;
        for (int it = 0; it < 40; it++) begin
            n_state = 6'($urandom);
            x = 1'($urandom);
            f = ($urandom_range(0, 3) == 0);
            node = 2'($urandom_range(0, 3));
            g = m_guard(n_state, x);
            fire(f, node, rdy, en_o, gid, rej);
            tests++; if (rdy !== (|g)) begin fails++; $display("FAIL rnd_ready it=%0d: got %b want %b", it, rdy, |g); end
            if (!(|g)) begin
                tests++; if (en_o !== 3'b000 || rej !== 1'b0) begin fails++; $display("FAIL rnd_idle it=%0d: got en=%b rej=%b want 000/0", it, en_o, rej); end
            end else if (f) begin
                ok = (node < 2'd3) && g[node];
                exp_en = ok ? (3'b001 << node) : 3'b000;
                tests++; if (en_o !== exp_en || rej !== !ok) begin fails++; $display("FAIL rnd_force it=%0d node=%0d: got en=%b rej=%b want %b/%b", it, node, en_o, rej, exp_en, !ok); end
                if (ok) m_last = node;
            end else begin
                w = m_rr(g, m_last);
                tests++; if (en_o !== (3'b001 << w) || gid !== w) begin fails++; $display("FAIL rnd_rr it=%0d: got en=%b gid=%0d want node %0d", it, en_o, gid, w); end
                m_last = w;
            end
        end
    endtask

`ifdef MUTEX_SCHED_STARVE_CHECK_EN
    task automatic test_starve_disabled();
        logic       rdy, rej;
        logic [2:0] en_o;
        logic [1:0] gid, w;
        apply_reset();
        n_state = 6'b000100;
        x = 1'b0;
        for (int i = 0; i < 8; i++) begin
            w = m_rr(m_guard(n_state, x), m_last);
            fire(1'b0, 2'd0, rdy, en_o, gid, rej);
            tests++; if (gid !== w) begin fails++; $display("FAIL sd_grant i=%0d: got %0d want %0d", i, gid, w); end
            m_last = w;
        end
        x = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        tests++; if (starve_err !== 1'b0) begin fails++; $display("FAIL sd_flag: got %b want 0", starve_err); end
    endtask

    task automatic test_starve_forced();
        logic       rdy, rej;
        logic [2:0] en_o;
        logic [1:0] gid;
        apply_reset();
        n_state = 6'b000000;
        x = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            fire(1'b1, 2'd0, rdy, en_o, gid, rej);
            tests++; if (starve_err !== (i >= 8)) begin fails++; $display("FAIL sf_flag i=%0d: got %b want %b", i, starve_err, i >= 8); end
        end
        apply_reset();
        tests++; if (starve_err !== 1'b0) begin fails++; $display("FAIL sf_reset: got %b want 0", starve_err); end
    endtask
`else
    task automatic test_starve_off();
        tests++; if (starve_err !== 1'b0) begin fails++; $display("FAIL starve_off: got %b want 0", starve_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_deadlock();
        test_force_reject();
        test_reset_mid_issue();
        test_random();
`ifdef MUTEX_SCHED_STARVE_CHECK_EN
        test_starve_disabled();
        test_starve_forced();
`else
        test_starve_off();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
